// File: rtl/run_checker.sv
// Run-length and sequence checker for a repeating counter stream: every value must
// hold for exactly REPEAT_LIMIT samples and step by +1 modulo MAX_CNT+1.
module run_checker #(
  parameter int REPEAT_LIMIT = 5,
  parameter int MAX_CNT      = 9,
  parameter int N            = 4,
  parameter int L            = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] cnt_in,
  output logic         new_val,
  output logic [N-1:0] val_out,
  output logic [L-1:0] run_len,
  output logic         wrap,
  output logic [7:0]   wrap_cnt,
  output logic         err,
  output logic [2:0]   err_code
);

  typedef enum logic [1:0] {INIT, SYNC, TRACK, FAULT} state_t;

  localparam logic [2:0]   E_NONE  = 3'd0;
  localparam logic [2:0]   E_SHORT = 3'd1;
  localparam logic [2:0]   E_LONG  = 3'd2;
  localparam logic [2:0]   E_SEQ   = 3'd3;
  localparam logic [2:0]   E_RANGE = 3'd4;
  localparam logic [N-1:0] MAX_V   = N'(MAX_CNT);
  localparam logic [L-1:0] LIM_V   = L'(REPEAT_LIMIT);

  state_t         state, state_nx;
  logic [N-1:0]   prev, prev_nx, val_out_nx, succ;
  logic [L-1:0]   rcnt, rcnt_nx, run_len_nx;
  logic [7:0]     wrap_cnt_nx;
  logic [2:0]     err_code_nx, fault;
  logic           new_val_nx, wrap_nx, err_nx;
  logic           same, range_f;

  always_comb begin
    state_nx    = state;
    prev_nx     = prev;
    rcnt_nx     = rcnt;
    new_val_nx  = 1'b0;
    wrap_nx     = 1'b0;
    val_out_nx  = val_out;
    run_len_nx  = run_len;
    wrap_cnt_nx = wrap_cnt;
    err_nx      = err;
    err_code_nx = err_code;
    fault       = E_NONE;
    succ        = (prev == MAX_V) ? '0 : prev + 1'b1;
    same        = (cnt_in == prev);
    range_f     = (cnt_in > MAX_V);

    case (state)
      INIT: begin
        prev_nx  = cnt_in;
        state_nx = SYNC;
        if (range_f) fault = E_RANGE;
      end
      SYNC: begin
        // first partial run is only used to find a run boundary
        prev_nx = cnt_in;
        if (!same) begin
          rcnt_nx  = L'(1);
          state_nx = TRACK;
        end
        if (range_f) fault = E_RANGE;
      end
      TRACK: begin
        if (range_f)               fault = E_RANGE;
        else if (same) begin
          if (rcnt == LIM_V)       fault = E_LONG;
          else                     rcnt_nx = rcnt + L'(1);
        end
        else if (cnt_in != succ)   fault = E_SEQ;
        else if (rcnt < LIM_V)     fault = E_SHORT;
        else begin
          new_val_nx = 1'b1;
          val_out_nx = cnt_in;
          run_len_nx = rcnt;
          rcnt_nx    = L'(1);
          prev_nx    = cnt_in;
          if (prev == MAX_V) begin
            wrap_nx     = 1'b1;
            wrap_cnt_nx = wrap_cnt + 8'd1;
          end
        end
      end
      FAULT: ;
      default: state_nx = INIT;
    endcase

    // a faulting sample leaves the tracking state untouched and freezes everything
    if (fault != E_NONE) begin
      state_nx    = FAULT;
      prev_nx     = prev;
      rcnt_nx     = rcnt;
      new_val_nx  = 1'b0;
      wrap_nx     = 1'b0;
      val_out_nx  = val_out;
      run_len_nx  = run_len;
      wrap_cnt_nx = wrap_cnt;
      err_nx      = 1'b1;
      err_code_nx = fault;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      prev     <= '0;
      rcnt     <= '0;
      new_val  <= 1'b0;
      val_out  <= '0;
      run_len  <= '0;
      wrap     <= 1'b0;
      wrap_cnt <= '0;
      err      <= 1'b0;
      err_code <= E_NONE;
    end else begin
      state    <= state_nx;
      prev     <= prev_nx;
      rcnt     <= rcnt_nx;
      new_val  <= new_val_nx;
      val_out  <= val_out_nx;
      run_len  <= run_len_nx;
      wrap     <= wrap_nx;
      wrap_cnt <= wrap_cnt_nx;
      err      <= err_nx;
      err_code <= err_code_nx;
    end
  end

endmodule

// File: tb/tb_run_checker.sv
// Bench for run_checker: hand-computed vector table, explicit legal-stream and
// reset sequences, then a random stream checked against a history-based model.
module tb_run_checker;

  localparam int REPEAT_LIMIT = 5;
  localparam int MAX_CNT      = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cnt_in = 4'd0;
  logic       new_val, wrap, err;
  logic [3:0] val_out;
  logic [2:0] run_len, err_code;
  logic [7:0] wrap_cnt;

  run_checker #(.REPEAT_LIMIT(REPEAT_LIMIT), .MAX_CNT(MAX_CNT), .N(4), .L(3)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .new_val(new_val), .val_out(val_out),
    .run_len(run_len), .wrap(wrap), .wrap_cnt(wrap_cnt), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       new_val;
    logic [3:0] val_out;
    logic [2:0] run_len;
    logic       wrap;
    logic [7:0] wrap_cnt;
    logic       err;
    logic [2:0] err_code;
  } obs_t;

  typedef struct {
    bit   r;
    int   c;
    obs_t exp;
  } vec_t;

  vec_t tbl[$];
  int   hist[$];   // samples accepted since the last reset
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic obs_t sample();
    return {new_val, val_out, run_len, wrap, wrap_cnt, err, err_code};
  endfunction

  // Replays the whole post-reset history against the run rules.
  function automatic obs_t model();
    obs_t e = '0;
    int rs = 0, v, p, len;
    bit trk = 0;
    for (int i = 0; i < hist.size(); i++) begin
      v = hist[i];
      e.new_val = 1'b0;
      e.wrap    = 1'b0;
      if (v > MAX_CNT) begin e.err = 1'b1; e.err_code = 3'd4; break; end
      if (i == 0) continue;
      p = hist[i-1];
      if (!trk) begin
        if (v != p) begin trk = 1; rs = i; end
        continue;
      end
      len = i - rs;
      if (v == p) begin
        if (len >= REPEAT_LIMIT) begin e.err = 1'b1; e.err_code = 3'd2; break; end
      end else if (v != (p + 1) % (MAX_CNT + 1)) begin
        e.err = 1'b1; e.err_code = 3'd3; break;
      end else if (len < REPEAT_LIMIT) begin
        e.err = 1'b1; e.err_code = 3'd1; break;
      end else begin
        e.new_val = 1'b1;
        e.val_out = 4'(v);
        e.run_len = 3'(len);
        if (v == 0) begin e.wrap = 1'b1; e.wrap_cnt = e.wrap_cnt + 8'd1; end
        rs = i;
      end
    end
    return e;
  endfunction

  task automatic step(input bit r, input int c);
    @(negedge clk);
    rst    = r;
    cnt_in = 4'(c);
    @(posedge clk);
    #1;
    if (r) hist.delete();
    else   hist.push_back(c);
  endtask

  task automatic check(input string name, input obs_t a, input obs_t x);
    n_assert++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s @%0t: got nv=%0d vo=%0d rl=%0d wr=%0d wc=%0d er=%0d ec=%0d, expected nv=%0d vo=%0d rl=%0d wr=%0d wc=%0d er=%0d ec=%0d",
               name, $time, a.new_val, a.val_out, a.run_len, a.wrap, a.wrap_cnt, a.err, a.err_code,
               x.new_val, x.val_out, x.run_len, x.wrap, x.wrap_cnt, x.err, x.err_code);
    end
  endtask

  task automatic add(input bit r, input int c, input int nv, input int vo, input int rl,
                     input int wr, input int wc, input int er, input int ec);
    vec_t t;
    t.r = r;
    t.c = c;
    t.exp = {1'(nv), 4'(vo), 3'(rl), 1'(wr), 8'(wc), 1'(er), 3'(ec)};
    tbl.push_back(t);
  endtask

  task automatic add_z(input bit r, input int c, input int n);
    for (int i = 0; i < n; i++) add(r, c, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    obs_t e;
    int   v, e_vo, e_rl, e_wc, gen_val, gen_left, c;
    bit   r, last_err;

    // SHORT: 3 x 3 then 4
    add_z(1, 0, 1); add_z(0, 2, 2); add_z(0, 3, 3);
    add(0, 4, 0, 0, 0, 0, 0, 1, 1);
    add(0, 5, 0, 0, 0, 0, 0, 1, 1);
    // LONG: sixth sample of 3
    add_z(1, 0, 1); add_z(0, 2, 1); add_z(0, 3, 5);
    add(0, 3, 0, 0, 0, 0, 0, 1, 2);
    add(0, 4, 0, 0, 0, 0, 0, 1, 2);
    // SEQ: 5 x 3 then 5
    add_z(1, 0, 1); add_z(0, 2, 1); add_z(0, 3, 5);
    add(0, 5, 0, 0, 0, 0, 0, 1, 3);
    // RANGE beats SEQ: 5 x 3 then 12
    add_z(1, 0, 1); add_z(0, 2, 1); add_z(0, 3, 5);
    add(0, 12, 0, 0, 0, 0, 0, 1, 4);
    // legal change after a full run
    add_z(1, 0, 1); add_z(0, 2, 1); add_z(0, 3, 5);
    add(0, 4, 1, 4, 5, 0, 0, 0, 0);
    add(0, 4, 0, 4, 5, 0, 0, 0, 0);
    // 9 -> 0 wrap
    add_z(1, 0, 1); add_z(0, 8, 1); add_z(0, 9, 5);
    add(0, 0, 1, 0, 5, 1, 1, 0, 0);
    add(0, 0, 0, 0, 5, 0, 1, 0, 0);
    // RANGE in INIT and in SYNC
    add_z(1, 0, 1); add(0, 15, 0, 0, 0, 0, 0, 1, 4);
    add_z(1, 0, 1); add_z(0, 1, 1); add(0, 13, 0, 0, 0, 0, 0, 1, 4);
    // non-successor change during sync is not checked
    add_z(1, 0, 1); add_z(0, 5, 1); add_z(0, 7, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].c);
      check($sformatf("vec%0d", i), sample(), tbl[i].exp);
    end

    // legal upstream stream from a faulted state: one-cycle reset then normal operation
    step(1, 0);
    check("rst_from_fault", sample(), '0);
    e_vo = 0; e_rl = 0; e_wc = 0;
    for (int k = 0; k < 70; k++) begin
      v = (7 + (k + 3) / 5) % 10;
      step(0, v);
      e = '0;
      if (k >= 7 && (k + 3) % 5 == 0) begin
        e.new_val = 1'b1;
        e_vo = v;
        e_rl = 5;
        if (v == 0) begin e.wrap = 1'b1; e_wc++; end
      end
      e.val_out  = 4'(e_vo);
      e.run_len  = 3'(e_rl);
      e.wrap_cnt = 8'(e_wc);
      check("legal_stream", sample(), e);
    end

    // reset in the middle of a run; the partial run afterwards must not fault
    for (int k = 70; k < 73; k++) begin
      step(0, (7 + (k + 3) / 5) % 10);
      check("pre_midrun", sample(), model());
    end
    step(1, 0);
    check("midrun_rst", sample(), '0);
    for (int k = 73; k < 110; k++) begin
      step(0, (7 + (k + 3) / 5) % 10);
      e = model();
      check("post_midrun", sample(), e);
    end
    e = '0;
    check("post_midrun_err", {7'd0, 1'b0, 8'd0, err, err_code}, e);

    // random stream: mostly legal counter, occasional glitches, run-length slips and resets
    gen_val  = $urandom_range(0, 9);
    gen_left = $urandom_range(1, 5);
    last_err = 0;
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 149) == 0) || (last_err && $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 249) == 0) c = $urandom_range(0, 15);
      else begin
        c = gen_val;
        gen_left--;
        if (gen_left == 0) begin
          gen_val  = (gen_val + 1) % 10;
          gen_left = ($urandom_range(0, 79) == 0) ? $urandom_range(4, 6) : 5;
        end
      end
      step(r, c);
      e = model();
      check("random", sample(), e);
      last_err = e.err;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/run_checker.md
RUN_CHECKER -- requirements
Module: run_checker

Interface
REQ-001 SHALL have parameter REPEAT_LIMIT, default 5: required length of every run of identical input values.
REQ-002 SHALL have parameter MAX_CNT, default 9: largest legal input value; the value after MAX_CNT is 0.
REQ-003 SHALL have parameter N, default 4: input/value width.
REQ-004 SHALL have parameter L, default 3: run-length counter width, with 2^L-1 >= REPEAT_LIMIT.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port cnt_in, input, N: sampled value stream from the upstream repeating counter.
REQ-008 SHALL have port new_val, output, 1: one-cycle pulse marking a checked value change.
REQ-009 SHALL have port val_out, output, N: the new value accompanying new_val.
REQ-010 SHALL have port run_len, output, L: length of the run that just ended, valid with new_val.
REQ-011 SHALL have port wrap, output, 1: one-cycle pulse on a legal MAX_CNT->0 transition.
REQ-012 SHALL have port wrap_cnt, output, 8: count of wrap pulses, modulo 256.
REQ-013 SHALL have port err, output, 1: sticky fault flag.
REQ-014 SHALL have port err_code, output, 3: first fault; 0 none, 1 SHORT, 2 LONG, 3 SEQ, 4 RANGE.

Function
REQ-015 SHALL register all outputs; a response to the cnt_in sample taken at edge k SHALL be visible after edge k.
REQ-016 SHALL hold internal registers prev (N bits), rcnt (L bits) and state, which takes one of INIT, SYNC, TRACK or FAULT.
REQ-017 SHALL, in INIT, load prev<=cnt_in and go to SYNC, with no checks except RANGE.
REQ-018 SHALL, in SYNC, load prev<=cnt_in each cycle and, when cnt_in!=prev, load rcnt<=1 and go to TRACK; the first partial run is not length-checked and no new_val is issued.
REQ-019 SHALL, in TRACK with cnt_in==prev, increment rcnt; if rcnt==REPEAT_LIMIT before the increment, raise LONG.
REQ-020 SHALL, in TRACK with cnt_in!=prev, raise SHORT if rcnt<REPEAT_LIMIT.
REQ-021 SHALL, in TRACK with cnt_in!=prev, raise SEQ if cnt_in != (prev==MAX_CNT ? 0 : prev+1).
REQ-022 SHALL, in TRACK with cnt_in!=prev and no fault, pulse new_val for one cycle with val_out<=cnt_in and run_len<=rcnt, then load rcnt<=1 and prev<=cnt_in.
REQ-023 SHALL, on a fault-free change where prev==MAX_CNT and cnt_in==0, pulse wrap in the same cycle as new_val and increment wrap_cnt, wrapping 255->0.
REQ-024 SHALL raise RANGE whenever cnt_in>MAX_CNT in INIT, SYNC or TRACK.
REQ-025 SHALL, when several faults occur on one sample, record only the highest priority: RANGE > SEQ > SHORT > LONG.
REQ-026 SHALL, on any fault, set err<=1, latch err_code, suppress new_val and wrap for that sample, and go to FAULT.
REQ-027 SHALL hold FAULT until rst: no further pulses, and err, err_code, wrap_cnt, val_out and run_len frozen.
REQ-028 SHALL drive new_val and wrap low in every cycle not described above.

Reset
REQ-029 SHALL, while rst is high at an edge, set state<=INIT, prev<=0, rcnt<=0, new_val<=0, val_out<=0, run_len<=0, wrap<=0, wrap_cnt<=0, err<=0 and err_code<=0.
REQ-030 SHALL treat rst as taking priority over every other update, including in FAULT and mid-run; the cnt_in sample on a reset edge SHALL be ignored.
REQ-031 SHALL accept rst asserted for one cycle as a complete reset.

Verification
REQ-032 SHALL cover: drive the upstream counter (REPEAT_LIMIT=5, MAX_CNT=9) with common rst -> after the first change, new_val every 5 cycles, run_len=5, val_out 1,2,...,9,0; wrap with val_out=0, wrap_cnt=1 after the first 9->0 change; err=0 throughout.
REQ-033 SHALL cover: in TRACK, drive 3 x 3 then 4 -> err=1, err_code=1 (SHORT), no new_val for 4.
REQ-034 SHALL cover: in TRACK, drive 6 x 3 -> err_code=2 (LONG) after the 6th sample.
REQ-035 SHALL cover: in TRACK, drive 5 x 3 then 5 -> err_code=3 (SEQ); drive 5 x 3 then 12 -> err_code=4 (RANGE, priority over SEQ).
REQ-036 SHALL cover: in FAULT, drive rst for 1 cycle, then a legal stream -> all outputs 0, then normal operation per REQ-032.
REQ-037 SHALL cover: drive rst mid-run in TRACK -> rcnt and wrap_cnt cleared, state INIT, the first partial run after reset is not flagged.
